// File: rtl/parity_seek_pkg.sv
// parity_seek_pkg: shared state encoding, default widths and seek-direction helper
package parity_seek_pkg;
  typedef enum logic [1:0] {IDLE, SEEK, DONE} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_W = 4;
  // Forward when the modular distance to the target is at most half the ring; the tie goes forward
  function automatic logic seek_fwd(input logic [31:0] tgt, input logic [31:0] cnt, input int w);
    logic [31:0] mask;
    logic [31:0] d;
    mask = (32'd1 << w) - 32'd1;
    d = (tgt - cnt) & mask;
    return d <= (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/parity_step_counter.sv
// parity_step_counter: counter that fixes parity by +1, otherwise steps +/-2 (mod 2^W)
module parity_step_counter import parity_seek_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         p,
  input  logic         f,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (en) count <= count[0] != p ? count + W'(1) : f ? count + W'(2) : count - W'(2);
endmodule

// File: rtl/parity_seek_sched.sv
// parity_seek_sched: round-robin scheduler driving a shared parity-step counter to each requester's target.
// Define PARITY_SEEK_SCHED_ABORT_EN to abort service when the granted requester drops req during SEEK.
module parity_seek_sched import parity_seek_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] target,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic              busy,
  output logic              p_cmd,
  output logic              f_cmd,
  output logic              step_en,
  output logic [W-1:0]      count,
  output logic              aborted
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [W-1:0] tgt_q;
  logic found;
  logic at_tgt;
  logic abort_c;
  int j;
  // First requesting index strictly after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    j = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick = IW'(j);
      end
    end
  end
  assign at_tgt = count == tgt_q;
`ifdef PARITY_SEEK_SCHED_ABORT_EN
  assign abort_c = state == SEEK && !(|(req & grant));
`else
  assign abort_c = 1'b0;
`endif
  assign p_cmd = state == SEEK && tgt_q[0];
  assign f_cmd = state == SEEK && seek_fwd(32'(tgt_q), 32'(count), W);
  assign step_en = state == SEEK && !at_tgt && !abort_c;
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign aborted = abort_c;
  parity_step_counter #(.W(W)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (step_en),
    .p     (p_cmd),
    .f     (f_cmd),
    .count (count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= IW'(NREQ - 1);
      tgt_q <= '0;
      grant <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          tgt_q <= target[int'(pick)*W +: W];
          grant <= NREQ'(1) << pick;
          rr_ptr <= pick;
          state <= SEEK;
        end
        SEEK: if (abort_c) begin
          grant <= '0;
          state <= IDLE;
        end else if (at_tgt) state <= DONE;
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_seek_sched.sv
// tb_parity_seek_sched: directed self-checking bench for parity_seek_sched (NREQ=4, W=4)
module tb_parity_seek_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] target = '0;
  logic [3:0] grant;
  logic done, busy, p_cmd, f_cmd, step_en, aborted;
  logic [3:0] count;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  parity_seek_sched #(.NREQ(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .grant(grant), .done(done), .busy(busy),
    .p_cmd(p_cmd), .f_cmd(f_cmd), .step_en(step_en), .count(count), .aborted(aborted)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; target = 16'hFFFF;
    tick; tick;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (step_en !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL reset_step_abort: got %b%b want 00", step_en, aborted); end
    rst = 1'b0; req = '0; target = '0;
    tick;
    total++; if (busy !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL reset_idle: busy %b grant %b want 0 0000", busy, grant); end
  endtask
  // Each phase: requester idx seeks tg; sq lists count per SEEK cycle, last entry equals the target
  task automatic run_phases(input string name, input int np, input int idx[3], input logic [3:0] tg[3],
                            input int n[3], input logic [3:0] sq[3][6], input logic fw[3]);
    for (int p = 0; p < np; p++) begin
      req = 4'(1) << idx[p]; target = 16'(tg[p]) << (4 * idx[p]);
      tick;
      total++; if (grant !== req) begin bad++; $display("FAIL %s_grant%0d: got %b want %b", name, p, grant, req); end
      for (int i = 0; i < n[p]; i++) begin
        logic se;
        se = i < n[p] - 1;
        total++;
        if (count !== sq[p][i] || step_en !== se || (se && (f_cmd !== fw[p] || p_cmd !== tg[p][0]))) begin
          bad++;
          $display("FAIL %s_step%0d_%0d: got cnt=%0d en=%b f=%b p=%b want cnt=%0d en=%b f=%b p=%b",
                   name, p, i, count, step_en, f_cmd, p_cmd, sq[p][i], se, fw[p], tg[p][0]);
        end
        tick;
      end
      total++; if (done !== 1'b1 || grant !== req) begin bad++; $display("FAIL %s_done%0d: got done=%b grant=%b want 1 %b", name, p, done, grant, req); end
      req = '0;
      tick;
      total++; if (done !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL %s_release%0d: got done=%b grant=%b want 0 0000", name, p, done, grant); end
    end
  endtask
  task automatic test_forward;
    run_phases("fwd", 1, '{0, 0, 0}, '{4'd7, 4'd0, 4'd0}, '{5, 0, 0},
               '{'{4'd0, 4'd1, 4'd3, 4'd5, 4'd7, 4'd0}, '{6{4'd0}}, '{6{4'd0}}}, '{1'b1, 1'b0, 1'b0});
  endtask
  task automatic test_wrap;
    run_phases("wrap", 2, '{2, 1, 0}, '{4'd1, 4'd13, 4'd0}, '{4, 3, 0},
               '{'{4'd7, 4'd5, 4'd3, 4'd1, 4'd0, 4'd0}, '{4'd1, 4'd15, 4'd13, 4'd0, 4'd0, 4'd0}, '{6{4'd0}}},
               '{1'b0, 1'b0, 1'b0});
  endtask
  task automatic test_tie;
    run_phases("tie", 3, '{3, 0, 1}, '{4'd0, 4'd8, 4'd8}, '{3, 5, 1},
               '{'{4'd13, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd0},
                 '{4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}}, '{1'b1, 1'b1, 1'b1});
  endtask
  task automatic test_round_robin;
    logic [3:0] eg;
    rst = 1'b1; req = 4'b0101; target = 16'h0000;
    tick; tick;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      eg = s % 2 == 0 ? 4'b0001 : 4'b0100;
      tick;
      total++; if (grant !== eg || step_en !== 1'b0) begin bad++; $display("FAIL rr_grant%0d: got %b en=%b want %b en=0", s, grant, step_en, eg); end
      tick;
      total++; if (done !== 1'b1 || grant !== eg) begin bad++; $display("FAIL rr_done%0d: got done=%b grant=%b want 1 %b", s, done, grant, eg); end
      tick;
      total++; if (done !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL rr_gap%0d: got done=%b grant=%b want 0 0000", s, done, grant); end
    end
    req = '0;
    tick;
  endtask
  task automatic test_req_drop;
    logic [3:0] ec[3] = '{4'd0, 4'd1, 4'd3};
    req = 4'b1010; target = 16'h9030;
    tick;
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL drop_grant: got %b want 1000", grant); end
    for (int i = 0; i < 3; i++) begin
      total++; if (count !== ec[i]) begin bad++; $display("FAIL drop_cnt%0d: got %0d want %0d", i, count, ec[i]); end
      if (i < 2) tick;
    end
    req = 4'b0010;
    #1;
`ifdef PARITY_SEEK_SCHED_ABORT_EN
    total++; if (aborted !== 1'b1 || step_en !== 1'b0) begin bad++; $display("FAIL abort_pulse: got ab=%b en=%b want 1 0", aborted, step_en); end
    tick;
    total++; if (count !== 4'd3 || grant !== 4'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      bad++; $display("FAIL abort_after: got cnt=%0d grant=%b done=%b ab=%b want 3 0000 0 0", count, grant, done, aborted);
    end
    tick;
    total++; if (grant !== 4'b0010 || count !== 4'd3) begin bad++; $display("FAIL abort_next_grant: got %b cnt=%0d want 0010 3", grant, count); end
    tick;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_next_done: got %b want 1", done); end
`else
    total++; if (aborted !== 1'b0 || step_en !== 1'b1) begin bad++; $display("FAIL noabort_pulse: got ab=%b en=%b want 0 1", aborted, step_en); end
    tick; tick; tick;
    total++; if (count !== 4'd9 || step_en !== 1'b0) begin bad++; $display("FAIL noabort_reach: got cnt=%0d en=%b want 9 0", count, step_en); end
    tick;
    total++; if (done !== 1'b1 || grant !== 4'b1000) begin bad++; $display("FAIL noabort_done: got done=%b grant=%b want 1 1000", done, grant); end
    tick; tick;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL noabort_next_grant: got %b want 0010", grant); end
    req = '0;
    begin
      int w;
      w = 0;
      while (done !== 1'b1 && w < 8) begin tick; w++; end
      total++; if (done !== 1'b1 || count !== 4'd3) begin bad++; $display("FAIL noabort_next_done: got done=%b cnt=%0d want 1 3", done, count); end
    end
`endif
    req = '0;
    tick;
    total++; if (busy !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL drop_idle: got busy=%b ab=%b want 0 0", busy, aborted); end
  endtask
  initial begin
    test_reset;
    test_forward;
    test_wrap;
    test_tie;
    test_round_robin;
    test_req_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
